// File: rtl/iterative_divider_unit.sv
// Purpose : multi-cycle radix-2 restoring divider for RV32M/RV64M DIV/DIVU/REM/REMU.
// Latency : normal ops valid at T+K+2 (K = XLEN-S quotient bits), special cases at T+2.
// Backpressure: none; start is taken only in IDLE, anything else is dropped (no queueing).
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   start, kill         request (decoded against opcode/funct7/funct3) and pipeline flush
//   opcode/funct7/funct3 instruction fields selecting the operation
//   accuracy_level      number of quotient LSBs to skip (approximate builds only)
//   bus_rs1, bus_rs2    dividend and divisor, latched on accept
//   div_unit_busy       high while an op is in CALC/FIX/SPECIAL
//   div_valid           one-cycle result pulse
//   div_output          quotient or remainder, held until the next result
module iterative_divider_unit #(
  parameter int XLEN        = 32,
  parameter int APPROXIMATE = 0,
  parameter int ACCURACY    = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [6:0]      opcode,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [7:0]      accuracy_level,
  input  logic [XLEN-1:0] bus_rs1,
  input  logic [XLEN-1:0] bus_rs2,
  output logic            div_unit_busy,
  output logic            div_valid,
  output logic [XLEN-1:0] div_output
);

  localparam int CW = $clog2(XLEN);
  localparam bit APPROX_EN = (APPROXIMATE != 0) && (ACCURACY != 0);
  localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CALC    = 3'd1,
    FIX     = 3'd2,
    SPECIAL = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t          state;
  logic [XLEN-1:0] rem_q;      // partial remainder
  logic [XLEN-1:0] dvd_q;      // dividend magnitude, shifted out MSB first
  logic [XLEN-1:0] quo_q;      // quotient bits collected so far
  logic [XLEN-1:0] dsr_q;      // divisor magnitude
  logic [XLEN-1:0] abs_a_q;    // unshifted dividend magnitude, source of the skipped low bits
  logic [XLEN-1:0] special_q;  // precomputed result for divide-by-zero / overflow
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   shift_q;    // number of skipped quotient LSBs
  logic            is_rem_q;
  logic            neg_q_q;
  logic            neg_r_q;

  // Decode and operand preparation for the accept cycle
  logic            accept;
  logic            is_signed;
  logic            is_rem;
  logic            a_neg;
  logic            b_neg;
  logic            is_special;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN-1:0] special_res;
  logic [CW-1:0]   s_in;

  assign accept = start && !kill && (state == IDLE) && (opcode == 7'b0110011) &&
                  (funct7 == 7'b0000001) && funct3[2];

  always_comb begin
    is_signed   = ~funct3[0];
    is_rem      = funct3[1];
    a_neg       = is_signed & bus_rs1[XLEN-1];
    b_neg       = is_signed & bus_rs2[XLEN-1];
    abs_a       = a_neg ? -bus_rs1 : bus_rs1;
    abs_b       = b_neg ? -bus_rs2 : bus_rs2;
    is_special  = 1'b0;
    special_res = '0;
    if (bus_rs2 == '0) begin
      is_special  = 1'b1;
      special_res = is_rem ? bus_rs1 : '1;
    end else if (is_signed && (bus_rs1 == MIN_INT) && (bus_rs2 == '1)) begin
      is_special  = 1'b1;
      special_res = is_rem ? '0 : MIN_INT;
    end
    s_in = '0;
    if (APPROX_EN) begin
      if (32'(accuracy_level) >= 32'(XLEN - 1)) s_in = CW'(XLEN - 1);
      else                                      s_in = CW'(accuracy_level);
    end
  end

  // One restoring step: the extra top bit catches a shifted remainder that exceeds XLEN bits
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  assign shifted = {rem_q, dvd_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dsr_q};

  // Final correction: skipped quotient LSBs are zero, so the corresponding dividend bits
  // are folded back into the remainder to keep q*d+r equal to the dividend.
  logic [XLEN-1:0] q_mag;
  logic [XLEN-1:0] r_mag;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  always_comb begin
    q_mag = quo_q << shift_q;
    r_mag = (rem_q << shift_q) | (abs_a_q & ((ONE << shift_q) - ONE));
    q_fix = neg_q_q ? -q_mag : q_mag;
    r_fix = neg_r_q ? -r_mag : r_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      div_unit_busy <= 1'b0;
      div_valid     <= 1'b0;
      div_output    <= '0;
    end else begin
      div_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rem_q         <= '0;
            dvd_q         <= abs_a;
            quo_q         <= '0;
            dsr_q         <= abs_b;
            abs_a_q       <= abs_a;
            special_q     <= special_res;
            shift_q       <= s_in;
            cnt_q         <= CW'(XLEN - 1) - s_in;
            is_rem_q      <= is_rem;
            neg_q_q       <= a_neg ^ b_neg;
            neg_r_q       <= a_neg;
            div_unit_busy <= 1'b1;
            state         <= is_special ? SPECIAL : CALC;
          end
        end
        CALC: begin
          if (kill) begin
            div_unit_busy <= 1'b0;
            state         <= IDLE;
          end else begin
            dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
            if (!diff[XLEN]) begin
              rem_q <= diff[XLEN-1:0];
              quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
              rem_q <= shifted[XLEN-1:0];
              quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) state <= FIX;
          end
        end
        FIX: begin
          div_unit_busy <= 1'b0;
          if (kill) begin
            state <= IDLE;
          end else begin
            div_output <= is_rem_q ? r_fix : q_fix;
            div_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        SPECIAL: begin
          div_unit_busy <= 1'b0;
          if (kill) begin
            state <= IDLE;
          end else begin
            div_output <= special_q;
            div_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          div_unit_busy <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider_unit.sv
module tb_iterative_divider_unit;

  localparam logic [6:0] OPC  = 7'b0110011;
  localparam logic [2:0] DIV  = 3'b100;
  localparam logic [2:0] DIVU = 3'b101;
  localparam logic [2:0] REM  = 3'b110;
  localparam logic [2:0] REMU = 3'b111;

  logic        clk;
  logic        reset;
  logic        start;
  logic        kill;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [7:0]  accuracy_level;
  logic [31:0] bus_rs1;
  logic [31:0] bus_rs2;
  logic        div_unit_busy;
  logic        div_valid;
  logic [31:0] div_output;

  iterative_divider_unit #(.XLEN(32), .APPROXIMATE(1), .ACCURACY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill),
    .opcode(opcode), .funct7(funct7), .funct3(funct3),
    .accuracy_level(accuracy_level), .bus_rs1(bus_rs1), .bus_rs2(bus_rs2),
    .div_unit_busy(div_unit_busy), .div_valid(div_valid), .div_output(div_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nerr = 0;
  int nchk = 0;

  // Reference model state: one outstanding op plus the output it should leave behind
  bit          chk_en = 1'b0;
  bit          active = 1'b0;
  int          t_acc = 0;
  int          due = 0;
  int          stop = 0;
  int          clr_at = -1;
  logic [31:0] pending = '0;
  logic [31:0] exp_out = '0;
  int          last_vcyc = -1;
  logic [31:0] last_val = '0;
  int          vcount = 0;
  int          busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Division from the arithmetic definition, not from the shift/subtract datapath
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b, input int s);
    logic        sgn, isrem, an, bn;
    logic [31:0] aa, ba, q, r;
    sgn   = ~f3[0];
    isrem = f3[1];
    if (b == 32'h0) return isrem ? a : 32'hFFFFFFFF;
    if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) return isrem ? 32'h0 : 32'h80000000;
    an = sgn & a[31];
    bn = sgn & b[31];
    aa = an ? -a : a;
    ba = bn ? -b : b;
    q  = ((aa >> s) / ba) << s;
    r  = aa - q * ba;
    if (an ^ bn) q = -q;
    if (an) r = -r;
    return isrem ? r : q;
  endfunction

  always @(negedge clk) begin : compare
    logic ev, eb;
    if (chk_en) begin
      if (cyc == clr_at) exp_out = 32'h0;
      ev = active && (cyc == due) && (due < stop);
      eb = active && (cyc > t_acc) && (cyc < due) && (cyc < stop);
      if (ev) exp_out = pending;
      check("valid", 32'(div_valid), 32'(ev));
      check("busy", 32'(div_unit_busy), 32'(eb));
      check("output", div_output, exp_out);
      if (div_valid) begin
        last_vcyc = cyc;
        last_val  = div_output;
        vcount++;
      end
      if (div_unit_busy) busy_cnt++;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [7:0] lvl, input logic [6:0] f7, input bit with_kill);
    bit acc;
    int s;
    bit special;
    start          = 1'b1;
    kill           = with_kill;
    opcode         = OPC;
    funct7         = f7;
    funct3         = f3;
    accuracy_level = lvl;
    bus_rs1        = a;
    bus_rs2        = b;
    acc = (f7 == 7'h01) && f3[2] && !with_kill && !(active && cyc <= due && cyc < stop);
    if (acc) begin
      s         = (lvl > 8'd31) ? 31 : int'(lvl);
      special   = (b == 32'h0) || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
      t_acc     = cyc;
      due       = cyc + (special ? 2 : 32 - s + 2);
      stop      = 32'h3FFFFFFF;
      pending   = model(f3, a, b, s);
      active    = 1'b1;
      last_vcyc = -1;
      vcount    = 0;
      busy_cnt  = 0;
    end
    @(posedge clk);
    #1;
    start          = 1'b0;
    kill           = 1'b0;
    bus_rs1        = $urandom;
    bus_rs2        = $urandom;
    accuracy_level = 8'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = due - cyc + 1;
    if (n < 1) n = 1;
    wait_cycles(n);
  endtask

  task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [7:0] lvl);
    issue(f3, a, b, lvl, 7'h01, 1'b0);
    wait_done();
  endtask

  task automatic expect_result(input string name, input logic [31:0] val, input int lat);
    check(name, last_val, val);
    check({name, "_latency"}, 32'(last_vcyc - t_acc), 32'(lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, q, r;
    logic [2:0]  f3;
    logic [7:0]  lvl;
    reset = 1'b1; start = 1'b0; kill = 1'b0; opcode = '0; funct7 = '0; funct3 = '0;
    accuracy_level = '0; bus_rs1 = '0; bus_rs2 = '0;
    wait_cycles(3);
    reset  = 1'b0;
    chk_en = 1'b1;
    wait_cycles(1);
    check("reset_busy", 32'(div_unit_busy), 32'h0);
    check("reset_valid", 32'(div_valid), 32'h0);
    check("reset_output", div_output, 32'h0);

    // hand-computed anchors for the model itself
    check("model_divu", model(DIVU, 32'd100, 32'd7, 0), 32'd14);
    check("model_rem_neg", model(REM, 32'hFFFFFFF9, 32'd2, 0), 32'hFFFFFFFF);
    check("model_approx", model(DIVU, 32'd1000, 32'd3, 4), 32'h140);
    check("model_clamp", model(DIVU, 32'hFFFFFFFF, 32'd1, 31), 32'h80000000);

    run(DIVU, 32'd100, 32'd7, 8'd0);
    expect_result("divu_100_7", 32'd14, 34);
    check("divu_busy_cycles", 32'(busy_cnt), 32'd33);
    run(REMU, 32'd100, 32'd7, 8'd0);
    expect_result("remu_100_7", 32'd2, 34);

    run(DIV, 32'hFFFFFFF9, 32'd2, 8'd0);
    expect_result("div_m7_2", 32'hFFFFFFFD, 34);
    run(REM, 32'hFFFFFFF9, 32'd2, 8'd0);
    expect_result("rem_m7_2", 32'hFFFFFFFF, 34);
    run(DIV, 32'd7, 32'hFFFFFFFE, 8'd0);
    expect_result("div_7_m2", 32'hFFFFFFFD, 34);

    run(DIVU, 32'h12345678, 32'h0, 8'd0);
    expect_result("divu_by_zero", 32'hFFFFFFFF, 2);
    run(REMU, 32'h12345678, 32'h0, 8'd0);
    expect_result("remu_by_zero", 32'h12345678, 2);
    run(REM, 32'h80000000, 32'hFFFFFFFF, 8'd0);
    expect_result("rem_overflow", 32'h0, 2);
    run(DIV, 32'h80000000, 32'hFFFFFFFF, 8'd0);
    expect_result("div_overflow", 32'h80000000, 2);

    run(DIVU, 32'd1000, 32'd3, 8'd4);
    expect_result("approx_divu", 32'h140, 30);
    run(REMU, 32'd1000, 32'd3, 8'd4);
    expect_result("approx_remu", 32'd40, 30);
    run(DIVU, 32'hFFFFFFFF, 32'd1, 8'd200);
    expect_result("approx_clamp", 32'h80000000, 3);

    // start while busy is dropped; the buses are scrambled right after accept
    issue(DIVU, 32'd100, 32'd7, 8'd0, 7'h01, 1'b0);
    wait_cycles(3);
    issue(DIVU, 32'd1, 32'd1, 8'd0, 7'h01, 1'b0);
    wait_done();
    expect_result("busy_start_ignored", 32'd14, 34);

    // wrong funct7, and kill together with start, are never accepted
    issue(DIVU, 32'd50, 32'd5, 8'd0, 7'h00, 1'b0);
    wait_cycles(3);
    check("funct7_ignored", 32'(div_unit_busy), 32'h0);
    issue(DIVU, 32'd50, 32'd5, 8'd0, 7'h01, 1'b1);
    wait_cycles(3);
    check("kill_start_ignored", 32'(div_unit_busy), 32'h0);

    // kill during CALC: IDLE one cycle later, no pulse, previous output kept
    issue(DIV, 32'd1000, 32'd3, 8'd0, 7'h01, 1'b0);
    wait_cycles(4);
    kill = 1'b1;
    stop = cyc + 1;
    wait_cycles(1);
    kill = 1'b0;
    check("kill_busy_next", 32'(div_unit_busy), 32'h0);
    wait_cycles(35);
    check("kill_no_valid", 32'(vcount), 32'h0);
    check("kill_output_kept", div_output, 32'd14);

    // reset during CALC: op discarded and output cleared
    issue(DIVU, 32'd100, 32'd7, 8'd0, 7'h01, 1'b0);
    wait_cycles(9);
    reset  = 1'b1;
    stop   = cyc + 1;
    clr_at = cyc + 1;
    wait_cycles(1);
    reset = 1'b0;
    check("reset_mid_busy", 32'(div_unit_busy), 32'h0);
    wait_cycles(30);
    check("reset_no_valid", 32'(vcount), 32'h0);
    check("reset_output_zero", div_output, 32'h0);

    // identity sweep on DUT results alone
    for (int i = 0; i < 12; i++) begin
      a   = $urandom;
      b   = $urandom >> $urandom_range(0, 30);
      lvl = 8'($urandom_range(0, 6));
      f3  = (i % 2 == 0) ? DIVU : DIV;
      run(f3, a, b, lvl);
      q = last_val;
      run(f3 | 3'b010, a, b, lvl);
      r = last_val;
      check("identity_qd_r", q * b + r, a);
    end

    wait_cycles(2);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
